abcd_seq_gen: RTL and testbench

- Synthesizable stimulus generator that drives the four-signal pattern a ##1 b ##1 c ##CD_GAP d on one clock.
- Produces a programmable number of back-to-back iterations per start request, with a busy/done handshake and synchronous abort.
- Sits on the driving side of the a/b/c/d interface; its outputs must satisfy the team's s_ab ##1 s_cd protocol property when CD_GAP=2.

---
 rtl/abcd_seq_pkg.sv | 25 ++
 rtl/abcd_seq_gen.sv | 158 +++++++++++++++
 tb/tb_abcd_seq_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/abcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : abcd_seq_pkg
//  Purpose  : Shared types and limits for the a/b/c/d stimulus generator.
//             Holds the generator state encoding and the legal CD_GAP range.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package abcd_seq_pkg;

  // Generator phases; the width is explicit so the encoding stays stable.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PH_A   = 3'd1,
    PH_B   = 3'd2,
    PH_C   = 3'd3,
    PH_GAP = 3'd4,
    PH_D   = 3'd5
  } state_t;

  localparam int MIN_CD_GAP = 1;
  localparam int MAX_CD_GAP = 15;

endpackage : abcd_seq_pkg
`default_nettype wire

// File: rtl/abcd_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : abcd_seq_gen
//  Purpose  : Drives the pattern a ##1 b ##1 c ##CD_GAP d for a programmable
//             number of back-to-back iterations per start request, with a
//             busy/done handshake and synchronous abort.
//  Ports    :
//    clk        in   1      system clock, rising edge
//    rst        in   1      asynchronous active-high reset
//    start      in   1      begin a burst (sampled only when idle)
//    repeat_cnt in   CNT_W  iteration count, captured on accepted start
//    abort      in   1      synchronous abort of a running burst
//    a/b/c/d    out  1      phase pulses
//    busy       out  1      burst in progress
//    done       out  1      one-cycle pulse on normal burst completion
//    iter       out  CNT_W  zero-based current iteration index
//  Revision : 1.0 - initial release
// ============================================================================
module abcd_seq_gen
  import abcd_seq_pkg::*;
#(
  parameter int CD_GAP = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  localparam int c_GAP_W = $clog2(CD_GAP + 1);
  // The gap counter counts the cycles remaining after the current one, so a
  // CD_GAP-1 cycle gap is loaded with CD_GAP-2. Unused when CD_GAP is 1.
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD =
    c_GAP_W'((CD_GAP > 1) ? (CD_GAP - 2) : 0);

  generate
    if (CD_GAP < MIN_CD_GAP || CD_GAP > MAX_CD_GAP) begin : g_bad_cd_gap
      $error("abcd_seq_gen: CD_GAP=%0d outside %0d..%0d",
             CD_GAP, MIN_CD_GAP, MAX_CD_GAP);
    end
  endgenerate

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [CNT_W-1:0]   r_iter;
  logic [CNT_W-1:0]   w_iter_next;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [c_GAP_W-1:0] w_gap_next;
  logic               w_done_next;
  logic [CNT_W:0]     w_iter_inc;
  logic               r_a, r_b, r_c, r_d, r_busy, r_done;

  // One extra bit so an all-ones count still compares correctly.
  assign w_iter_inc = {1'b0, r_iter} + (CNT_W + 1)'(1);

  always_comb begin
    w_next_state = r_state;
    w_count_next = r_count;
    w_iter_next  = r_iter;
    w_gap_next   = r_gap_cnt;
    w_done_next  = 1'b0;

    if (abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // Abort outranks start even while idle.
          if (start && !abort) begin
            if (repeat_cnt != '0) begin
              w_next_state = PH_A;
              w_count_next = repeat_cnt;
              w_iter_next  = '0;
            end else begin
              w_done_next = 1'b1;
            end
          end
        end
        PH_A: w_next_state = PH_B;
        PH_B: w_next_state = PH_C;
        PH_C: begin
          if (CD_GAP > 1) begin
            w_next_state = PH_GAP;
            w_gap_next   = c_GAP_LOAD;
          end else begin
            w_next_state = PH_D;
          end
        end
        PH_GAP: begin
          if (r_gap_cnt == '0) begin
            w_next_state = PH_D;
          end else begin
            w_gap_next = r_gap_cnt - c_GAP_W'(1);
          end
        end
        PH_D: begin
          if (w_iter_inc < {1'b0, r_count}) begin
            w_next_state = PH_A;
            w_iter_next  = w_iter_inc[CNT_W-1:0];
          end else begin
            w_next_state = IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse lines up with
  // the state it belongs to while still coming straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_iter    <= '0;
      r_gap_cnt <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_c       <= 1'b0;
      r_d       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_count_next;
      r_iter    <= w_iter_next;
      r_gap_cnt <= w_gap_next;
      r_a       <= (w_next_state == PH_A);
      r_b       <= (w_next_state == PH_B);
      r_c       <= (w_next_state == PH_C);
      r_d       <= (w_next_state == PH_D);
      r_busy    <= (w_next_state != IDLE);
      r_done    <= w_done_next;
    end
  end

  assign a    = r_a;
  assign b    = r_b;
  assign c    = r_c;
  assign d    = r_d;
  assign busy = r_busy;
  assign done = r_done;
  assign iter = r_iter;

endmodule : abcd_seq_gen
`default_nettype wire

// File: tb/tb_abcd_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_abcd_seq_gen
//  Purpose  : Self-checking bench for abcd_seq_gen. Two instances run side by
//             side: CD_GAP=2/CNT_W=8 and CD_GAP=1/CNT_W=4, sharing control.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_abcd_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] cnt0;
  logic [3:0] cnt1;

  logic       a0, b0, c0, d0, busy0, done0;
  logic [7:0] iter0;
  logic       a1, b1, c1, d1, busy1, done1;
  logic [3:0] iter1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  abcd_seq_gen #(.CD_GAP(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .repeat_cnt(cnt0), .abort(abort),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .iter(iter0)
  );

  abcd_seq_gen #(.CD_GAP(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .repeat_cnt(cnt1), .abort(abort),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .iter(iter1)
  );

  // Behavioural model: a burst is "k cycles since its first a"; the phase is
  // k mod (3+gap) and the iteration is k div (3+gap).
  int gap_of [2] = '{2, 1};
  int m_busy [2] = '{0, 0};
  int m_k    [2] = '{0, 0};
  int m_n    [2] = '{0, 0};
  int m_iter [2] = '{0, 0};
  int m_done [2] = '{0, 0};

  task automatic model_step(input int i, input int cnt);
    int p;
    p = 3 + gap_of[i];
    if (rst) begin
      m_busy[i] = 0; m_k[i] = 0; m_n[i] = 0; m_iter[i] = 0; m_done[i] = 0;
    end else begin
      m_done[i] = 0;
      if (m_busy[i] != 0) begin
        if (abort) begin
          m_busy[i] = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == m_n[i] * p) begin
            m_busy[i] = 0;
            m_done[i] = 1;
          end else begin
            m_iter[i] = m_k[i] / p;
          end
        end
      end else if (start && !abort) begin
        if (cnt == 0) begin
          m_done[i] = 1;
        end else begin
          m_busy[i] = 1; m_k[i] = 0; m_n[i] = cnt; m_iter[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [13:0] model_vec(input int i);
    int   ph;
    logic bz;
    ph = m_k[i] % (3 + gap_of[i]);
    bz = (m_busy[i] != 0);
    return {bz && ph == 0, bz && ph == 1, bz && ph == 2,
            bz && ph == 2 + gap_of[i], bz, m_done[i] != 0, 8'(m_iter[i])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: advance the model on each rising edge, check after it.
  always @(posedge clk) begin
    model_step(0, int'(cnt0));
    model_step(1, int'(cnt1));
    #1;
    chk("model0", {18'd0, a0, b0, c0, d0, busy0, done0, iter0}, {18'd0, model_vec(0)});
    chk("model1", {18'd0, a1, b1, c1, d1, busy1, done1, 4'd0, iter1}, {18'd0, model_vec(1)});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'd1, 32'd0);
    tick();
  endtask

  logic [5:0] exp_single [7] = '{6'b100010, 6'b010010, 6'b001010, 6'b000010,
                                 6'b000110, 6'b000001, 6'b000000};

  initial begin
    int dc0, dc1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cnt0 = '0; cnt1 = '0;
    repeat (3) tick();
    chk("reset0", {18'd0, a0, b0, c0, d0, busy0, done0, iter0}, 32'd0);
    chk("reset1", {22'd0, a1, b1, c1, d1, busy1, done1, iter1}, 32'd0);
    rst = 1'b0;
    tick();

    // Single iteration: literal cycle-by-cycle pulses.
    start = 1'b1; cnt0 = 8'd1; cnt1 = 4'd1;
    tick();
    start = 1'b0;
    for (int cy = 0; cy < 7; cy++) begin
      chk("single", {26'd0, a0, b0, c0, d0, busy0, done0}, {26'd0, exp_single[cy]});
      tick();
    end
    wait_idle();

    // Back-to-back iterations; gap-1 instance runs two iterations.
    start = 1'b1; cnt0 = 8'd3; cnt1 = 4'd2;
    tick();
    start = 1'b0;
    dc0 = 0; dc1 = 0;
    for (int cy = 1; cy <= 20; cy++) begin
      if (done0 && dc0 == 0) dc0 = cy;
      if (done1 && dc1 == 0) dc1 = cy;
      if (cy == 11) chk("b2b_iter", {24'd0, iter0}, 32'd2);
      tick();
    end
    chk("b2b_done_cycle", dc0, 32'd16);
    chk("gap1_done_cycle", dc1, 32'd9);
    wait_idle();

    // Abort in the gap of the second iteration with start held high.
    start = 1'b1; cnt0 = 8'd4; cnt1 = 4'd4;
    tick();
    repeat (8) tick();
    chk("gap_before_abort", {27'd0, a0, b0, c0, d0, busy0}, 32'b00001);
    abort = 1'b1;
    tick();
    chk("abort_outputs", {26'd0, a0, b0, c0, d0, busy0, done0}, 32'd0);
    chk("abort_iter", {24'd0, iter0}, 32'd1);
    abort = 1'b0; start = 1'b0;
    repeat (4) tick();

    // Abort and start together while idle: abort wins.
    start = 1'b1; abort = 1'b1; cnt0 = 8'd2; cnt1 = 4'd2;
    tick();
    chk("abort_beats_start", {29'd0, busy0, done0, a0}, 32'd0);
    start = 1'b0; abort = 1'b0;
    tick();

    // Zero count on instance 0, maximum count on instance 1.
    start = 1'b1; cnt0 = 8'd0; cnt1 = 4'd15;
    tick();
    start = 1'b0;
    chk("zero_cnt", {26'd0, a0, b0, c0, d0, busy0, done0}, 32'b000001);
    tick();
    dc1 = 0;
    for (int cy = 2; cy <= 62; cy++) begin
      if (cy == 2) chk("zero_cnt_after", {30'd0, busy0, done0}, 32'd0);
      if (cy == 60) chk("max_last_iter", {27'd0, d1, iter1}, {27'd0, 1'b1, 4'd14});
      if (done1 && dc1 == 0) dc1 = cy;
      tick();
    end
    chk("max_done_cycle", dc1, 32'd61);
    wait_idle();

    // Asynchronous reset while instance 0 shows c of its first iteration.
    start = 1'b1; cnt0 = 8'd3; cnt1 = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_reset_c", {28'd0, a0, b0, c0, d0}, 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_reset0", {18'd0, a0, b0, c0, d0, busy0, done0, iter0}, 32'd0);
    chk("async_reset1", {22'd0, a1, b1, c1, d1, busy1, done1, iter1}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("no_done_after_reset", {31'd0, done0}, 32'd0);
    start = 1'b1; cnt0 = 8'd3; cnt1 = 4'd1;
    tick();
    start = 1'b0;
    dc0 = 0;
    for (int cy = 1; cy <= 18; cy++) begin
      if (done0 && dc0 == 0) dc0 = cy;
      tick();
    end
    chk("post_reset_done_cycle", dc0, 32'd16);
    wait_idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 99) < 30);
      abort = ($urandom_range(0, 99) < 4);
      cnt0  = 8'($urandom_range(0, 3));
      cnt1  = 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_abcd_seq_gen
`default_nettype wire
